// File: rtl/operand_collector.sv
// Issue-stage operand collector: accepts one dispatched instruction, reads its source
// operands from the register file, and queues the complete bundle for the execution units.
module operand_collector #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int WARP_W  = 5,
    parameter int LANES   = 32,
    parameter int PAY_W   = 63,
    parameter int DEPTH   = 4,
    localparam int OPND_W = 32 * LANES,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WARP_W-1:0]           in_warp_id,
    input  logic [NUM_SRC*REG_AW-1:0]   in_src_addr,
    input  logic [NUM_SRC-1:0]          in_src_used,
    input  logic [PAY_W-1:0]            in_payload,
    output logic [WARP_W-1:0]           rf_warp_id,
    output logic [NUM_SRC-1:0]          rf_req,
    output logic [NUM_SRC*REG_AW-1:0]   rf_addr,
    input  logic [NUM_SRC-1:0]          rf_rvalid,
    input  logic [NUM_SRC*OPND_W-1:0]   rf_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WARP_W-1:0]           out_warp_id,
    output logic [PAY_W-1:0]            out_payload,
    output logic [NUM_SRC*OPND_W-1:0]   out_opnd,
    output logic [CNT_W-1:0]            fifo_count,
    output logic                        fifo_full,
    output logic                        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] PUSH = 2'd2;

    logic [1:0]                  state;
    logic [NUM_SRC-1:0]          pending;
    logic [NUM_SRC-1:0]          pending_next;
    logic [WARP_W-1:0]           warp_r;
    logic [PAY_W-1:0]            pay_r;
    logic [NUM_SRC*REG_AW-1:0]   addr_r;
    logic [NUM_SRC*OPND_W-1:0]   opnd_r;
    logic                        bad_rvalid;
    logic                        push;
    logic                        pop;
    logic [PTR_W-1:0]            wptr;
    logic [PTR_W-1:0]            rptr;

    logic [WARP_W-1:0]           mem_warp [DEPTH];
    logic [PAY_W-1:0]            mem_pay  [DEPTH];
    logic [NUM_SRC*OPND_W-1:0]   mem_opnd [DEPTH];

    assign in_ready     = (state == IDLE);
    assign rf_warp_id   = warp_r;
    assign rf_addr      = addr_r;
    assign pending_next = pending & ~rf_rvalid;
    // Any return outside WAIT, or on a channel no longer pending, is a protocol violation.
    assign bad_rvalid   = |(rf_rvalid & ~((state == WAIT) ? pending : '0));

    assign fifo_full    = (fifo_count == CNT_W'(DEPTH));
    assign out_valid    = (fifo_count != '0);
    assign push         = (state == PUSH) && !fifo_full;
    assign pop          = out_valid && out_ready;
    assign out_warp_id  = mem_warp[rptr];
    assign out_payload  = mem_pay[rptr];
    assign out_opnd     = mem_opnd[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            warp_r  <= '0;
            pay_r   <= '0;
            addr_r  <= '0;
            opnd_r  <= '0;
            rf_req  <= '0;
            err     <= 1'b0;
        end else begin
            rf_req <= '0;
            err    <= err | bad_rvalid;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        warp_r  <= in_warp_id;
                        pay_r   <= in_payload;
                        addr_r  <= in_src_addr;
                        opnd_r  <= '0;
                        pending <= in_src_used;
                        rf_req  <= in_src_used;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (rf_rvalid[i] && pending[i])
                            opnd_r[i*OPND_W +: OPND_W] <= rf_rdata[i*OPND_W +: OPND_W];
                    end
                    pending <= pending_next;
                    if (pending_next == '0)
                        state <= PUSH;
                end
                PUSH: begin
                    // fifo_full is registered, so a same-cycle pop only frees space for next cycle.
                    if (!fifo_full)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wptr <= wptr + PTR_W'(1);
            if (pop)
                rptr <= rptr + PTR_W'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_warp[wptr] <= warp_r;
            mem_pay[wptr]  <= pay_r;
            mem_opnd[wptr] <= opnd_r;
        end
    end

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Parametrised issue-stage operand collector between the warp dispatcher and the execution units.
- Accepts one dispatched instruction at a time and requests up to NUM_SRC source operands from the register file.
- Gathers the returned operand vectors, then pushes {warp id, payload, operands} into an internal FIFO.
- The execution side drains the FIFO through a valid/ready handshake.

Parameters:
NUM_SRC, 2, number of source-operand channels
REG_AW, 5, register address width per operand
WARP_W, 5, warp id width
LANES, 32, threads per warp; operand vector width OPND_W = 32*LANES
PAY_W, 63, opaque instruction payload width
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  dispatch request valid
in_ready  out  1  collector can accept a request
in_warp_id  in  WARP_W  warp of request
in_src_addr  in  NUM_SRC*REG_AW  source register addresses, channel i at [i*REG_AW +: REG_AW]
in_src_used  in  NUM_SRC  per-channel operand-used mask
in_payload  in  PAY_W  instruction payload
rf_warp_id  out  WARP_W  warp id presented to register file
rf_req  out  NUM_SRC  per-channel one-cycle read request
rf_addr  out  NUM_SRC*REG_AW  per-channel read address
rf_rvalid  in  NUM_SRC  per-channel read data valid
rf_rdata  in  NUM_SRC*OPND_W  per-channel read data
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
out_warp_id  out  WARP_W  head warp id
out_payload  out  PAY_W  head payload
out_opnd  out  NUM_SRC*OPND_W  head operand vectors
fifo_count  out  $clog2(DEPTH)+1  occupied entries
fifo_full  out  1  count==DEPTH
err  out  1  sticky protocol error

Behaviour:
- Reset is asynchronous and clears everything:
  - state=IDLE, in_ready=1, rf_req=0, rf_addr=0, rf_warp_id=0.
  - Pointers=0, fifo_count=0, out_valid=0, fifo_full=0, err=0.
  - Captured operand registers are cleared to 0; an in-flight instruction is discarded.
- The FSM has three states: IDLE, WAIT, PUSH. in_ready = (state==IDLE).
- IDLE:
  - Transfer occurs when in_valid and in_ready are both high.
  - Register warp id, payload, addresses and used mask; clear all operand registers to 0.
  - Set pending = in_src_used and go to WAIT.
  - Next cycle: rf_req[i] = in_src_used[i] for exactly one cycle; rf_addr and rf_warp_id are held until the next accept.
- WAIT:
  - Each cycle, for every channel with rf_rvalid[i] and pending[i]: capture rf_rdata channel i and clear pending[i].
  - Data returning in the same cycle rf_req is high is accepted.
  - When pending is zero after this cycle's updates, go to PUSH.
  - With pending==0 on entry (no operands used), WAIT lasts one cycle.
  - Unused channels push zero operands.
- PUSH:
  - If !fifo_full: write the entry at the write pointer and go to IDLE.
  - Else hold in PUSH; no data is lost.
  - A pop in the same cycle does not unblock a full-FIFO push; the push retries the next cycle.
- FIFO:
  - Registered storage; the head is read combinationally from the read pointer.
  - out_valid = (count!=0). Pop when out_valid && out_ready.
  - Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
  - No empty bypass: an entry written at edge N is visible at out_valid after edge N.
- Minimum latency with all channels used and 1-cycle RF return:
  - Accept at edge 0, rf_req in cycle 1, rvalid in cycle 2, PUSH in cycle 3.
  - out_valid high from edge 4; next in_ready high from edge 4.
- err is set (sticky until reset) when rf_rvalid[i] is high while state!=WAIT or !pending[i]. The offending data is ignored.
- in_* inputs are don't-care while in_ready is low.

Test Plan:
- Reset mid-WAIT with channel 1 pending -> rf_req=0, out_valid=0, fifo_count=0, in_ready=1 one cycle after release.
- Warp 3, addr {7,9}, used=2'b11; RF returns ch0 data 0xA5A5... one cycle after req, ch1 three cycles after -> one entry, out_opnd ch0=0xA5A5..., ch1 as returned, out_warp_id=3, push exactly one cycle after the last rvalid.
- used=2'b00 -> rf_req never asserted; entry with zero operands; out_valid 3 cycles after accept.
- Both rvalid in the same cycle as rf_req -> captured; PUSH next cycle.
- out_ready=0, issue DEPTH+1=5 requests -> fifo_full after 4 entries; 5th holds in PUSH with in_ready=0; single pop -> 5th pushed the following cycle; order preserved through pointer wrap.
- rf_rvalid[0] pulsed while IDLE -> err=1, held through later traffic; FIFO contents unaffected.
